// File: rtl/regbank_arbiter.sv
// Round-robin arbiter/sequencer serialising two requesters onto a bank of registers.
// Each transaction runs IDLE -> BUSY -> DONE; the bank load decode is owned here.
module regbank_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0,
  input  logic                      we0,
  input  logic [ADDR_W-1:0]         addr0,
  input  logic [WIDTH-1:0]          wdata0,
  output logic                      ack0,
  output logic [WIDTH-1:0]          rdata0,
  input  logic                      req1,
  input  logic                      we1,
  input  logic [ADDR_W-1:0]         addr1,
  input  logic [WIDTH-1:0]          wdata1,
  output logic                      ack1,
  output logic [WIDTH-1:0]          rdata1,
  output logic [NUM_REGS-1:0]       bank_load,
  output logic [WIDTH-1:0]          bank_din,
  input  logic [NUM_REGS*WIDTH-1:0] bank_dout,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 gid_q, gid_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 ack0_q, ack0_d, ack1_q, ack1_d;
  logic [WIDTH-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [NUM_REGS-1:0]  bank_load_q, bank_load_d;
  logic [WIDTH-1:0]     bank_din_q, bank_din_d;
  logic                 busy_q, busy_d;
  logic                 gnt;
  logic [WIDTH-1:0]     rd_slice;

  assign rd_slice = bank_dout[addr_q*WIDTH +: WIDTH];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    we_d         = we_q;
    addr_d       = addr_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    bank_load_d  = bank_load_q;
    bank_din_d   = bank_din_q;
    gnt          = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Under contention the requester not served last time wins.
          gnt    = (req0 && req1) ? ~last_grant_q : req1;
          gid_d  = gnt;
          we_d   = gnt ? we1 : we0;
          addr_d = gnt ? addr1 : addr0;
          if (we_d) begin
            bank_load_d         = '0;
            bank_load_d[addr_d] = 1'b1;
            bank_din_d          = gnt ? wdata1 : wdata0;
          end
          state_d = BUSY;
        end
      end
      BUSY: begin
        bank_load_d = '0;
        if (!we_q) begin
          if (gid_q) rdata1_d = rd_slice;
          else       rdata0_d = rd_slice;
        end
        ack0_d  = ~gid_q;
        ack1_d  = gid_q;
        state_d = DONE;
      end
      DONE: begin
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        last_grant_d = gid_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      bank_load_q  <= '0;
      bank_din_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      bank_load_q  <= bank_load_d;
      bank_din_q   <= bank_din_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign bank_load = bank_load_q;
  assign bank_din  = bank_din_q;
  assign busy      = busy_q;

endmodule
